// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, FSM states, mode words and timing constants
// shared by the toggle-handshake SDRAM port.
package sdram_pkg;
    // {nCS, nRAS, nCAS, nWE}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_DESL = 4'b1111;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MODE,
        S_IDLE, S_ACT, S_RW, S_WAIT, S_REFRESH
    } state_e;

    // burst length 1, sequential, single-location write
    localparam logic [12:0] MODE_CL2 = 13'h220;
    localparam logic [12:0] MODE_CL3 = 13'h230;

    localparam int T_RP        = 2;
    localparam int T_RC        = 5;
    localparam int T_RCD       = 2;
    localparam int T_MRD       = 2;
    localparam int T_WAIT_IDLE = 3;

    function automatic logic [12:0] mode_word(input int cas_lat);
        return (cas_lat == 3) ? MODE_CL3 : MODE_CL2;
    endfunction
endpackage

// File: rtl/sdram_toggle_port.sv
// sdram_toggle_port: single-port SDRAM responder for a toggle req/ack port;
// handles power-up init, periodic auto-refresh and auto-precharged accesses.
module sdram_toggle_port
    import sdram_pkg::*;
#(
    parameter int INIT_CYCLES    = 7200,
    parameter int REFRESH_CYCLES = 540,
    parameter int CAS_LAT        = 2
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        port_req,
    output logic        port_ack,
    input  logic [15:0] port_a,
    input  logic [1:0]  port_ds,
    input  logic        port_we,
    input  logic [15:0] port_d,
    output logic [15:0] port_q,
    output logic [12:0] SDRAM_A,
    output logic [1:0]  SDRAM_BA,
    inout  wire  [15:0] SDRAM_DQ,
    output logic        SDRAM_DQML,
    output logic        SDRAM_DQMH,
    output logic        SDRAM_nCS,
    output logic        SDRAM_nRAS,
    output logic        SDRAM_nCAS,
    output logic        SDRAM_nWE
);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic        ref_pend_q, ref_pend_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [12:0] a_q, a_d;
    logic [1:0]  dqm_q, dqm_d, ds_q, ds_d;
    logic        dq_oe_q, dq_oe_d, ack_q, ack_d, req_q, req_d, we_q, we_d;
    logic [15:0] q_q, q_d, d_q, d_d;
    logic [8:0]  col_q, col_d;
    logic        run, expire, go_ref;

    assign run    = state_q >= S_IDLE;
    assign expire = run && (rcnt_q == 16'(REFRESH_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        cmd_d   = CMD_NOP;
        a_d     = a_q;
        dqm_d   = 2'b11;
        dq_oe_d = 1'b0;
        ack_d   = ack_q;
        q_d     = q_q;
        req_d   = req_q;
        we_d    = we_q;
        d_d     = d_q;
        col_d   = col_q;
        ds_d    = ds_q;
        go_ref  = 1'b0;
        case (state_q)
            S_INIT_WAIT: if (cnt_q == '0) begin
                state_d = S_INIT_PRE;
                cmd_d   = CMD_PRE;
                a_d     = 13'h400;
                cnt_d   = 16'(T_RP - 1);
            end
            S_INIT_PRE: if (cnt_q == '0) begin
                state_d = S_INIT_REF1;
                cmd_d   = CMD_REF;
                cnt_d   = 16'(T_RC - 1);
            end
            S_INIT_REF1: if (cnt_q == '0) begin
                state_d = S_INIT_REF2;
                cmd_d   = CMD_REF;
                cnt_d   = 16'(T_RC - 1);
            end
            S_INIT_REF2: if (cnt_q == '0) begin
                state_d = S_INIT_MODE;
                cmd_d   = CMD_MRS;
                a_d     = mode_word(CAS_LAT);
                cnt_d   = 16'(T_MRD - 1);
            end
            S_INIT_MODE: if (cnt_q == '0) state_d = S_IDLE;
            S_IDLE: if (ref_pend_q) begin
                // the IDLE decision cycle counts toward the refresh's tRC
                state_d = S_REFRESH;
                cmd_d   = CMD_REF;
                cnt_d   = 16'(T_RC - 2);
                go_ref  = 1'b1;
            end else if (port_req != ack_q) begin
                state_d = S_ACT;
                cmd_d   = CMD_ACT;
                a_d     = {6'b0, port_a[15:9]};
                cnt_d   = 16'(T_RCD - 1);
                req_d   = port_req;
                we_d    = port_we;
                d_d     = port_d;
                ds_d    = port_ds;
                col_d   = port_a[8:0];
            end
            S_ACT: if (cnt_q == '0) begin
                state_d = S_RW;
                cmd_d   = we_q ? CMD_WR : CMD_RD;
                a_d     = {3'b001, 1'b0, col_q};
                dqm_d   = we_q ? ~ds_q : 2'b00;
                dq_oe_d = we_q;
            end
            S_RW: begin
                state_d = S_WAIT;
                cnt_d   = 16'(T_WAIT_IDLE - 1 + (we_q ? 0 : CAS_LAT - 2));
                ack_d   = we_q ? req_q : ack_q;
            end
            S_WAIT: begin
                // cnt_q == 1 lands exactly CAS_LAT cycles after READ
                if (!we_q && cnt_q == 16'd1) begin
                    q_d   = SDRAM_DQ;
                    ack_d = req_q;
                end
                if (cnt_q == '0) state_d = S_IDLE;
            end
            S_REFRESH: if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_INIT_WAIT;
        endcase
        rcnt_d     = (!run || expire) ? '0 : rcnt_q + 16'd1;
        ref_pend_d = go_ref ? 1'b0 : (expire ? 1'b1 : ref_pend_q);
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q    <= S_INIT_WAIT;
            cnt_q      <= 16'(INIT_CYCLES);
            rcnt_q     <= '0;
            ref_pend_q <= 1'b0;
            cmd_q      <= CMD_DESL;
            a_q        <= '0;
            dqm_q      <= 2'b11;
            dq_oe_q    <= 1'b0;
            ack_q      <= 1'b0;
            q_q        <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            d_q        <= '0;
            col_q      <= '0;
            ds_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            ref_pend_q <= ref_pend_d;
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            dqm_q      <= dqm_d;
            dq_oe_q    <= dq_oe_d;
            ack_q      <= ack_d;
            q_q        <= q_d;
            req_q      <= req_d;
            we_q       <= we_d;
            d_q        <= d_d;
            col_q      <= col_d;
            ds_q       <= ds_d;
        end
    end

    assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd_q;
    assign SDRAM_A                  = a_q;
    assign SDRAM_BA                 = 2'b00;
    assign {SDRAM_DQMH, SDRAM_DQML} = dqm_q;
    assign SDRAM_DQ                 = dq_oe_q ? d_q : 16'hzzzz;
    assign port_ack                 = ack_q;
    assign port_q                   = q_q;
endmodule
